// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, board type, start position,
// piece-class helpers and sequencer state encoding.
package chess_pkg;

  localparam logic [3:0] W_ROOK   = 4'd0;
  localparam logic [3:0] W_KNIGHT = 4'd1;
  localparam logic [3:0] W_BISHOP = 4'd2;
  localparam logic [3:0] W_QUEEN  = 4'd3;
  localparam logic [3:0] W_KING   = 4'd4;
  localparam logic [3:0] W_PAWN   = 4'd5;
  localparam logic [3:0] B_ROOK   = 4'd6;
  localparam logic [3:0] B_KNIGHT = 4'd7;
  localparam logic [3:0] B_BISHOP = 4'd8;
  localparam logic [3:0] B_QUEEN  = 4'd9;
  localparam logic [3:0] B_KING   = 4'd10;
  localparam logic [3:0] B_PAWN   = 4'd11;
  localparam logic [3:0] EMPTY    = 4'd15;

  // board[y][x]; y=0 is the black back rank
  typedef logic [3:0] board_t [8][8];

  localparam board_t INIT_BOARD = '{
    '{B_ROOK, B_KNIGHT, B_BISHOP, B_QUEEN, B_KING, B_BISHOP, B_KNIGHT, B_ROOK},
    '{default: B_PAWN},
    '{default: EMPTY},
    '{default: EMPTY},
    '{default: EMPTY},
    '{default: EMPTY},
    '{default: W_PAWN},
    '{W_ROOK, W_KNIGHT, W_BISHOP, W_QUEEN, W_KING, W_BISHOP, W_KNIGHT, W_ROOK}
  };

  // sequencer states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_REJECT = 3'd4;

  function automatic logic is_white(input logic [3:0] p);
    return p <= W_PAWN;
  endfunction

  function automatic logic is_black(input logic [3:0] p);
    return (p >= B_ROOK) && (p <= B_PAWN);
  endfunction

  function automatic logic is_pawn(input logic [3:0] p);
    return (p == W_PAWN) || (p == B_PAWN);
  endfunction

  function automatic logic is_king(input logic [3:0] p);
    return (p == W_KING) || (p == B_KING);
  endfunction

  // piece belongs to the side to move (t: 0 white, 1 black)
  function automatic logic is_own(input logic [3:0] p, input logic t);
    return t ? is_black(p) : is_white(p);
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Sequencer <-> move-legality validator bus, all coordinates in view space.
interface move_sequencer_if;
  import chess_pkg::*;

  logic [2:0] v_old_x, v_old_y, v_new_x, v_new_y;
  logic [3:0] v_piece_type;
  board_t     v_board;
  logic       v_valid_input;
  logic       v_valid_move, v_valid_output;

  modport master (
    output v_old_x, v_old_y, v_new_x, v_new_y, v_piece_type, v_board, v_valid_input,
    input  v_valid_move, v_valid_output
  );

  modport slave (
    input  v_old_x, v_old_y, v_new_x, v_new_y, v_piece_type, v_board, v_valid_input,
    output v_valid_move, v_valid_output
  );
endinterface

// File: rtl/board_view_rotator.sv
// Side-to-move view of the board: identity for white, 180-degree turn for
// black so forward always means decreasing row. Also used by the display path.
module board_view_rotator
  import chess_pkg::*;
(
  input  board_t board,
  input  logic   turn,
  output board_t view
);

  // one mux per square
  for (genvar y = 0; y < 8; y++) begin : g_row
    for (genvar x = 0; x < 8; x++) begin : g_col
      assign view[y][x] = turn ? board[7-y][7-x] : board[y][x];
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Turn-based move controller: owns the board and side to move, pairs cursor
// selects into moves, asks the validator, and commits or rejects.
module move_sequencer
  import chess_pkg::*;
#(
  parameter int CHECK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_valid,
  input  logic [2:0] sel_x,
  input  logic [2:0] sel_y,
  input  logic       cancel,
  move_sequencer_if.master vbus,
  output board_t     board_out,
  output logic       turn,
  output logic       src_active,
  output logic [2:0] src_x,
  output logic [2:0] src_y,
  output logic       move_done,
  output logic       move_reject,
  output logic       busy
);

  localparam int TW = $clog2(CHECK_TIMEOUT) + 1;

  logic [2:0]    state;
  board_t        board;
  logic [2:0]    dst_x, dst_y;
  logic [TW-1:0] timer;

  logic [3:0] sel_p, src_p, dst_p, moved_p;
  logic [2:0] vo_x, vo_y, vn_x, vn_y;
  logic       sel_own, sel_same, pre_ok, promote;

  assign sel_p    = board[sel_y][sel_x];
  assign src_p    = board[src_y][src_x];
  assign dst_p    = board[dst_y][dst_x];
  assign sel_own  = is_own(sel_p, turn);
  assign sel_same = (sel_x == src_x) && (sel_y == src_y);

  // 7-c on 3 bits is bitwise inversion
  assign vo_x = turn ? ~src_x : src_x;
  assign vo_y = turn ? ~src_y : src_y;
  assign vn_x = turn ? ~dst_x : dst_x;
  assign vn_y = turn ? ~dst_y : dst_y;

  // local guard: pawns only advance, and kings are never captured
  assign pre_ok  = !(is_pawn(src_p) && !(vn_y < vo_y)) && !is_king(dst_p);
  assign promote = is_pawn(src_p) && (vn_y == 3'd0);
  assign moved_p = promote ? (turn ? B_QUEEN : W_QUEEN) : src_p;

  board_view_rotator u_rot (
    .board (board),
    .turn  (turn),
    .view  (vbus.v_board)
  );

  assign vbus.v_old_x       = vo_x;
  assign vbus.v_old_y       = vo_y;
  assign vbus.v_new_x       = vn_x;
  assign vbus.v_new_y       = vn_y;
  assign vbus.v_piece_type  = src_p;
  assign vbus.v_valid_input = (state == S_CHECK);

  assign board_out   = board;
  assign move_done   = (state == S_COMMIT);
  assign move_reject = (state == S_REJECT);
  assign busy        = (state == S_CHECK) || (state == S_COMMIT);

  // selection FSM, validator wait and board commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      board      <= INIT_BOARD;
      turn       <= 1'b0;
      src_active <= 1'b0;
      src_x      <= '0;
      src_y      <= '0;
      dst_x      <= '0;
      dst_y      <= '0;
      timer      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!cancel && sel_valid && sel_own) begin
            src_x      <= sel_x;
            src_y      <= sel_y;
            src_active <= 1'b1;
            state      <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (cancel) begin
            src_active <= 1'b0;
            state      <= S_IDLE;
          end else if (sel_valid) begin
            if (sel_same) begin
              src_active <= 1'b0;
              state      <= S_IDLE;
            end else if (sel_own) begin
              src_x <= sel_x;
              src_y <= sel_y;
            end else begin
              dst_x <= sel_x;
              dst_y <= sel_y;
              timer <= '0;
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (cancel) begin
            src_active <= 1'b0;
            state      <= S_IDLE;
          end else if (vbus.v_valid_output) begin
            if (vbus.v_valid_move && pre_ok) begin
              board[dst_y][dst_x] <= moved_p;
              board[src_y][src_x] <= EMPTY;
              turn                <= ~turn;
              state               <= S_COMMIT;
            end else begin
              state <= S_REJECT;
            end
          end else if (timer == TW'(CHECK_TIMEOUT - 1)) begin
            state <= S_REJECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COMMIT, S_REJECT: begin
          src_active <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a stub validator driven from the
// stimulus sequence; expected board tracked by hand-applied move edits.
module tb_move_sequencer;
  import chess_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel_valid = 1'b0;
  logic       cancel = 1'b0;
  logic [2:0] sel_x = '0;
  logic [2:0] sel_y = '0;
  board_t     board_out;
  board_t     exp_b;
  logic       turn, src_active, move_done, move_reject, busy;
  logic [2:0] src_x, src_y;
  int         nvec = 0;
  int         nerr = 0;

  move_sequencer_if vbus ();

  move_sequencer #(.CHECK_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .sel_valid   (sel_valid),
    .sel_x       (sel_x),
    .sel_y       (sel_y),
    .cancel      (cancel),
    .vbus        (vbus),
    .board_out   (board_out),
    .turn        (turn),
    .src_active  (src_active),
    .src_x       (src_x),
    .src_y       (src_y),
    .move_done   (move_done),
    .move_reject (move_reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic board_t start_board();
    board_t b;
    b = '{
      '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd8, 4'd7, 4'd6},
      '{default: 4'd11},
      '{default: 4'd15},
      '{default: 4'd15},
      '{default: 4'd15},
      '{default: 4'd15},
      '{default: 4'd5},
      '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd2, 4'd1, 4'd0}
    };
    return b;
  endfunction

  function automatic int bdiff();
    int n = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (board_out[y][x] !== exp_b[y][x]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input logic [2:0] x, input logic [2:0] y);
    sel_valid = 1'b1;
    sel_x = x;
    sel_y = y;
    tick();
    sel_valid = 1'b0;
  endtask

  initial begin
    vbus.v_valid_output = 1'b1;
    vbus.v_valid_move   = 1'b1;
    exp_b = start_board();

    // reset
    tick();
    tick();
    reset = 1'b0;
    chk("rst_board", bdiff(), 0);
    chk("rst_turn", turn, 0);
    chk("rst_src_active", src_active, 0);
    chk("rst_src_xy", {src_x, src_y}, 0);
    chk("rst_pulses", {move_done, move_reject}, 0);
    chk("rst_vin_busy", {vbus.v_valid_input, busy}, 0);

    // white pawn e2-e4: (4,6) -> (4,4)
    pick(3'd4, 3'd6);
    chk("w_src", {src_active, src_x, src_y}, {1'b1, 3'd4, 3'd6});
    pick(3'd4, 3'd4);
    chk("w_vin_busy", {vbus.v_valid_input, busy}, 2'b11);
    chk("w_old", {vbus.v_old_x, vbus.v_old_y}, {3'd4, 3'd6});
    chk("w_new", {vbus.v_new_x, vbus.v_new_y}, {3'd4, 3'd4});
    chk("w_piece", vbus.v_piece_type, 5);
    chk("w_done_early", move_done, 0);
    tick();
    exp_b[4][4] = 4'd5;
    exp_b[6][4] = 4'd15;
    chk("w_done", move_done, 1);
    chk("w_board", bdiff(), 0);
    chk("w_turn", turn, 1);
    tick();
    chk("w_done_end", {move_done, busy}, 0);

    // black pawn (3,1) -> (3,3), seen rotated
    pick(3'd3, 3'd1);
    pick(3'd3, 3'd3);
    chk("b_old", {vbus.v_old_x, vbus.v_old_y}, {3'd4, 3'd6});
    chk("b_new", {vbus.v_new_x, vbus.v_new_y}, {3'd4, 3'd4});
    chk("b_piece", vbus.v_piece_type, 11);
    chk("b_view_src", vbus.v_board[6][4], 11);
    chk("b_view_corner", vbus.v_board[0][0], 0);
    chk("b_view_wpawn", vbus.v_board[3][3], 5);
    tick();
    exp_b[3][3] = 4'd11;
    exp_b[1][3] = 4'd15;
    chk("b_done", move_done, 1);
    chk("b_board", bdiff(), 0);
    chk("b_turn", turn, 0);
    tick();

    // validator says illegal: knight (6,7) -> (6,5)
    vbus.v_valid_move = 1'b0;
    pick(3'd6, 3'd7);
    pick(3'd6, 3'd5);
    tick();
    chk("n_pulses", {move_done, move_reject}, 2'b01);
    chk("n_board", bdiff(), 0);
    chk("n_turn", turn, 0);
    tick();
    chk("n_reject_end", move_reject, 0);
    vbus.v_valid_move = 1'b1;

    // re-selection and deselect
    pick(3'd0, 3'd7);
    chk("rs_first", {src_x, src_y}, {3'd0, 3'd7});
    pick(3'd1, 3'd7);
    chk("rs_relatch", {src_active, src_x, src_y}, {1'b1, 3'd1, 3'd7});
    chk("rs_not_check", {vbus.v_valid_input, busy}, 0);
    pick(3'd1, 3'd7);
    chk("rs_deselect", src_active, 0);

    // silent validator: reject after the timeout
    vbus.v_valid_output = 1'b0;
    pick(3'd1, 3'd7);
    pick(3'd2, 3'd5);
    for (int i = 0; i < 4; i++) begin
      chk("to_wait", {vbus.v_valid_input, move_reject}, 2'b10);
      tick();
    end
    chk("to_reject", {vbus.v_valid_input, move_reject}, 2'b01);
    chk("to_board", bdiff(), 0);
    tick();
    chk("to_turn", turn, 0);

    // cancel in CHECK: back to idle with no pulse
    pick(3'd1, 3'd7);
    pick(3'd2, 3'd5);
    chk("cc_in_check", vbus.v_valid_input, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cc_idle", {vbus.v_valid_input, src_active, move_reject}, 0);
    tick();
    chk("cc_no_pulse", {move_done, move_reject}, 0);
    vbus.v_valid_output = 1'b1;

    // cancel beats a simultaneous select
    pick(3'd1, 3'd7);
    cancel = 1'b1;
    pick(3'd2, 3'd5);
    cancel = 1'b0;
    chk("cs_idle", {src_active, vbus.v_valid_input}, 0);

    // pawn walk to promotion
    pick(3'd2, 3'd6);
    pick(3'd2, 3'd1);
    tick();
    exp_b[1][2] = 4'd5;
    exp_b[6][2] = 4'd15;
    chk("p1_done", move_done, 1);
    tick();
    pick(3'd7, 3'd1);
    pick(3'd7, 3'd2);
    tick();
    exp_b[2][7] = 4'd11;
    exp_b[1][7] = 4'd15;
    chk("p2_done", move_done, 1);
    tick();
    pick(3'd2, 3'd1);
    pick(3'd2, 3'd0);
    chk("p3_new", {vbus.v_new_x, vbus.v_new_y}, {3'd2, 3'd0});
    tick();
    exp_b[0][2] = 4'd3;
    exp_b[1][2] = 4'd15;
    chk("p3_done", move_done, 1);
    chk("p3_queen", board_out[0][2], 3);
    chk("p3_board", bdiff(), 0);
    chk("p3_turn", turn, 1);
    tick();

    // black pawn backwards (view row 5 -> 6) fails the pre-check
    pick(3'd7, 3'd2);
    pick(3'd7, 3'd1);
    tick();
    chk("bk_reject", {move_done, move_reject}, 2'b01);
    chk("bk_turn", turn, 1);
    tick();

    // king capture fails the pre-check
    pick(3'd0, 3'd0);
    pick(3'd4, 3'd7);
    tick();
    chk("kc_reject", {move_done, move_reject}, 2'b01);
    chk("kc_board", bdiff(), 0);
    tick();

    // reset in the middle of CHECK
    pick(3'd6, 3'd1);
    pick(3'd6, 3'd3);
    chk("rc_in_check", vbus.v_valid_input, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_b = start_board();
    chk("rc_board", bdiff(), 0);
    chk("rc_turn", turn, 0);
    chk("rc_state", {src_active, vbus.v_valid_input, busy}, 0);
    chk("rc_pulses", {move_done, move_reject}, 0);
    tick();
    chk("rc_no_late_commit", {move_done, bdiff() == 0}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
